// File: rtl/counter_pkg.sv
// Shared encodings for the up/down modulo counter: boundary mode and count direction,
// plus sizing of the prescaler phase register.
package counter_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } bound_mode_e;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_e;

    // A divide-by-1 prescaler still keeps a 1-bit phase so the register is never zero-width.
    function automatic int unsigned phase_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Emits a one-cycle tick every PRESCALE enabled cycles; phase holds while en=0.
// Tick is combinational from en and phase; sync_clr zeros the phase and suppresses the tick.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned       PW   = phase_width(PRESCALE);
    localparam logic [PW-1:0]     LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = en && !sync_clr && (phase == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (sync_clr || tick) begin
            phase <= '0;
        end else if (en) begin
            phase <= phase + PW'(1);
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MAX_VAL with wrap or saturate at the bounds, clear/load and a prescaled step.
// count, tc and at_bound are registered; with PRESCALE=1 a step lands on the first enabled edge.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int unsigned      PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_bound
);

    dir_e             dir;
    bound_mode_e      mode;
    logic             step;
    logic             hit_bound;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             at_bound_nxt;

    assign dir  = dir_e'(up_dn);
    assign mode = bound_mode_e'(sat);

    // Clear and load both restart the prescale phase, so any pending step is dropped.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (clr | load),
        .tick     (step)
    );

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        hit_bound = (dir == UP) ? (count == MAX_VAL) : (count == '0);
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            tc_nxt = hit_bound;
            if (dir == UP) begin
                count_nxt = !hit_bound ? count + WIDTH'(1) : ((mode == SAT) ? MAX_VAL : '0);
            end else begin
                count_nxt = !hit_bound ? count - WIDTH'(1) : ((mode == SAT) ? '0 : MAX_VAL);
            end
        end
        at_bound_nxt = (dir == UP) ? (count_nxt == MAX_VAL) : (count_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            tc       <= 1'b0;
            at_bound <= 1'b0;
        end else begin
            count    <= count_nxt;
            tc       <= tc_nxt;
            at_bound <= at_bound_nxt;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: three counter instances (4b/9/div1, 4b/9/div3, 8b/255/div1) share one stimulus stream.
module tb_updown_mod_counter;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic       up_dn    = 1'b1;
    logic       sat      = 1'b0;
    logic       clr      = 1'b0;
    logic       load     = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [3:0] cnt_a, cnt_b;
    logic [7:0] cnt_c;
    logic       tc_a, tc_b, tc_c;
    logic       at_a, at_b, at_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .sat(sat), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .count(cnt_a), .tc(tc_a), .at_bound(at_a)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .sat(sat), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .count(cnt_b), .tc(tc_b), .at_bound(at_b)
    );

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(8'd255), .PRESCALE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .sat(sat), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt_c), .tc(tc_c), .at_bound(at_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check_eq("rst_count_a", cnt_a, 0);
        check_eq("rst_tc_a", tc_a, 0);
        check_eq("rst_bound_a", at_a, 0);
        check_eq("rst_count_c", cnt_c, 0);

        // Up, wrap, 12 enabled cycles on the modulo-10 counter
        #11 rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("up_wrap_count", cnt_a, (i + 1) % 10);
            check_eq("up_wrap_tc", tc_a, i == 9);
            check_eq("up_wrap_bound", at_a, ((i + 1) % 10) == 9);
        end

        // Down, saturate, from 2
        en = 1'b0; up_dn = 1'b0; sat = 1'b1; load = 1'b1; load_val = 8'd2;
        tick();
        load = 1'b0;
        check_eq("dn_sat_load", cnt_a, 2);
        check_eq("dn_sat_load_tc", tc_a, 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("dn_sat_count", cnt_a, (i == 0) ? 1 : 0);
            check_eq("dn_sat_tc", tc_a, i >= 2);
            check_eq("dn_sat_bound", at_a, i >= 1);
        end

        // Prescale by 3, then an en gap of 2 cycles mid-phase
        up_dn = 1'b1; sat = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("pre_clr", cnt_b, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_eq("pre_count", cnt_b, k / 3);
        end
        for (int j = 0; j < 5; j++) begin
            en = (j != 1) && (j != 2);
            tick();
            check_eq("pre_gap_count", cnt_b, (j == 4) ? 4 : 3);
        end

        // Priority clr > load > step, and load clamping
        en = 1'b0; load = 1'b1; load_val = 8'd5;
        tick();
        check_eq("load5", cnt_a, 5);
        clr = 1'b1; en = 1'b1;
        tick();
        check_eq("clr_wins_count", cnt_a, 0);
        check_eq("clr_wins_tc", tc_a, 0);
        clr = 1'b0; load_val = 8'd15;
        tick();
        check_eq("load_clamp_count", cnt_a, 9);
        check_eq("load_clamp_tc", tc_a, 0);
        check_eq("load_clamp_bound", at_a, 1);
        tick();
        check_eq("load_over_step_count", cnt_a, 9);
        check_eq("load_over_step_tc", tc_a, 0);
        load_val = 8'd0;
        tick();
        load = 1'b0; up_dn = 1'b0;
        tick();
        check_eq("dn_wrap_count", cnt_a, 9);
        check_eq("dn_wrap_tc", tc_a, 1);
        check_eq("dn_wrap_bound", at_a, 0);

        // Asynchronous reset between edges at count 7; partial prescale phase discarded
        up_dn = 1'b1; en = 1'b0; load = 1'b1; load_val = 8'd6;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        check_eq("pre_rst_count", cnt_a, 7);
        en = 1'b0; up_dn = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_rst_count", cnt_a, 0);
        check_eq("async_rst_tc", tc_a, 0);
        check_eq("async_rst_bound", at_a, 0);
        check_eq("async_rst_count_b", cnt_b, 0);
        #2 rst_n = 1'b1;
        up_dn = 1'b1; en = 1'b1;
        tick();
        check_eq("post_rst_count", cnt_a, 1);
        check_eq("post_rst_b1", cnt_b, 0);
        tick();
        check_eq("post_rst_b2", cnt_b, 0);
        tick();
        check_eq("post_rst_b3", cnt_b, 1);

        // Full-range 8-bit wrap from 255
        en = 1'b0; load = 1'b1; load_val = 8'hFF;
        tick();
        load = 1'b0;
        check_eq("full_load", cnt_c, 255);
        check_eq("full_load_bound", at_c, 1);
        en = 1'b1;
        tick();
        check_eq("full_wrap_count", cnt_c, 0);
        check_eq("full_wrap_tc", tc_c, 1);
        check_eq("full_wrap_bound", at_c, 0);
        tick();
        check_eq("full_next_count", cnt_c, 1);
        check_eq("full_next_tc", tc_c, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: terminal value, legal range 1..2**WIDTH-1; the count range is 0..MAX_VAL.
REQ-003 SHALL have parameter PRESCALE, default 1: number of enabled clk cycles per count step, legal range 1..65535.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  count enable; gates the prescaler.
REQ-007 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL have port sat  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-009 SHALL have port clr  input  1  synchronous clear.
REQ-010 SHALL have port load  input  1  synchronous parallel load.
REQ-011 SHALL have port load_val  input  WIDTH  value to load.
REQ-012 SHALL have port count  output  WIDTH  current count, registered.
REQ-013 SHALL have port tc  output  1  registered one-cycle pulse marking a boundary step.
REQ-014 SHALL have port at_bound  output  1  registered level: count is at MAX_VAL (up) or 0 (down).

Function
REQ-015 SHALL evaluate controls in priority order clr > load > step, once per clk edge.
REQ-016 SHALL, on clr, set count=0 and zero the prescaler phase in the same edge.
REQ-017 SHALL, on load without clr, set count=min(load_val, MAX_VAL), zero the prescaler phase, and assert no tc.
REQ-018 SHALL generate a step when en=1 and the prescaler phase reaches PRESCALE-1; the phase then returns to 0.
REQ-019 SHALL hold the prescaler phase while en=0, so that a step occurs after PRESCALE cycles with en=1.
REQ-020 SHALL, on a step with PRESCALE=1, update count on the first edge on which en=1 (latency 1 clk).
REQ-021 SHALL, on an up step with count<MAX_VAL, set count=count+1; on a down step with count>0, set count=count-1.
REQ-022 SHALL, on an up step at MAX_VAL, set count to 0 when sat=0 and hold MAX_VAL when sat=1.
REQ-023 SHALL, on a down step at 0, set count to MAX_VAL when sat=0 and hold 0 when sat=1.
REQ-024 SHALL pulse tc high for exactly the one cycle following any step taken at a boundary (REQ-022/023), in either mode.
REQ-025 SHALL drive at_bound=1 when (up_dn=1 and count==MAX_VAL) or (up_dn=0 and count==0), registered from next-state values.
REQ-026 SHALL apply a change of up_dn or sat on the next step; it SHALL NOT reset the prescaler.
REQ-027 SHALL keep all arithmetic modulo-free within WIDTH bits, with no intermediate overflow when MAX_VAL=2**WIDTH-1.

Reset
REQ-028 SHALL, while rst_n=0, immediately set count=0, tc=0, at_bound=0 (up_dn-independent), and prescaler phase=0.
REQ-029 SHALL resume operation on the first clk edge after rst_n deasserts; reset mid-prescale discards the partial phase.

Structure
REQ-030 SHALL place the mode encodings (WRAP=0, SAT=1; DOWN=0, UP=1) in shared package counter_pkg.
REQ-031 SHALL implement the prescaler as sub-module tick_prescaler (ports clk, rst_n, en, sync_clr, tick), parameterised by PRESCALE.

Verification
REQ-032 SHALL cover: WIDTH=4, MAX_VAL=9, PRESCALE=1, up, wrap, 12 enabled cycles -> count 0..9,0,1,2; tc high exactly one cycle after the 9->0 step.
REQ-033 SHALL cover: down, sat=1, from load_val=2, 4 steps -> count 1,0,0,0; tc pulses after each held step at 0.
REQ-034 SHALL cover: PRESCALE=3, en held 1 for 9 cycles -> count increments on cycles 3, 6 and 9 only; en dropped for 2 cycles mid-phase -> next step is delayed by 2.
REQ-035 SHALL cover: clr, load(5) and a step in the same cycle -> count=0; load(15) with MAX_VAL=9 -> count=9, tc=0.
REQ-036 SHALL cover: rst_n asserted asynchronously between clk edges at count=7 -> count=0 before the next edge; first step after release -> count=1.
REQ-037 SHALL cover: WIDTH=8, MAX_VAL=255, up, wrap, count=255, one step -> count=0 with no X, tc=1.
